// File: rtl/fetch_stage.sv
// fetch_stage: PC and IF/ID register with a stall-aware request/ready fetch port
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        EXMEM_iord,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_pc4,
    output logic        IFID_valid,
    output logic [4:0]  IFID_rs,
    output logic [4:0]  IFID_rt
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_buf;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        w_advance;
    logic        w_got;
    logic        w_cap;
    logic [31:0] w_word;
    logic [31:0] w_pc_next;
    // Request drive and capture decode; an issued WAIT/DRAIN request stays up until ready
    always_comb begin
        w_advance = PCWrite && IFIDWrite;
        mem_req   = !reset && (r_state == S_REQ ? !EXMEM_iord : r_state != S_HOLD);
        mem_addr  = r_state == S_REQ ? r_pc : r_req_addr;
        w_got     = mem_req && mem_ready && (r_state == S_REQ || r_state == S_WAIT);
        w_cap     = w_advance && (w_got || r_state == S_HOLD);
        w_word    = r_state == S_HOLD ? r_buf : mem_rdata;
        w_pc_next = r_pc + PC_INC;
    end
    // Fetch FSM, PC, hold buffer and IF/ID register; flush overrides all stall inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf      <= 32'h0;
            r_instr    <= 32'h0;
            r_pc4      <= 32'h0;
            r_valid    <= 1'b0;
        end else begin
            if (r_state == S_REQ)
                r_req_addr <= r_pc;
            if (flush) begin
                r_pc    <= branch_target;
                r_instr <= 32'h0;
                r_valid <= 1'b0;
                r_state <= (mem_req && !mem_ready) ? S_DRAIN : S_REQ;
            end else begin
                if (w_cap) begin
                    r_instr <= w_word;
                    r_pc4   <= w_pc_next;
                    r_valid <= 1'b1;
                    r_pc    <= w_pc_next;
                end else if (IFIDWrite) begin
                    r_instr <= 32'h0;
                    r_valid <= 1'b0;
                end
                if (w_got && !w_advance) begin
                    r_buf   <= mem_rdata;
                    r_state <= S_HOLD;
                end else if (w_got)
                    r_state <= S_REQ;
                else if (r_state == S_REQ && mem_req)
                    r_state <= S_WAIT;
                else if (r_state == S_HOLD && w_advance)
                    r_state <= S_REQ;
                else if (r_state == S_DRAIN && mem_ready)
                    r_state <= S_REQ;
            end
        end
    end
    assign IFID_instr = r_instr;
    assign IFID_pc4   = r_pc4;
    assign IFID_valid = r_valid;
    assign IFID_rs    = r_instr[25:21];
    assign IFID_rt    = r_instr[20:16];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner and randomized run against a transaction-level model
module tb_fetch_stage;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b1, IFIDWrite = 1'b1, flush = 1'b0, EXMEM_iord = 1'b0, mem_ready = 1'b0;
    logic [31:0] branch_target = 32'h0, mem_rdata = 32'h0;
    logic        mem_req, IFID_valid;
    logic [31:0] mem_addr, IFID_instr, IFID_pc4;
    logic [4:0]  IFID_rs, IFID_rt;
    int n_chk = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .flush(flush),
        .branch_target(branch_target), .EXMEM_iord(EXMEM_iord), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .IFID_instr(IFID_instr), .IFID_pc4(IFID_pc4), .IFID_valid(IFID_valid),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt)
    );

    always #5 clk = ~clk;

    // Reference model: PC, one outstanding request, a discard flag for flushed requests,
    // a one-word buffer, and the IF/ID contents
    logic [31:0] m_pc, m_paddr, m_buf, m_instr, m_pc4;
    logic        m_pend, m_disc, m_hbuf, m_valid;

    typedef struct {
        logic pcw, ifw, fl;
        logic [31:0] bt;
        logic iord, rdy;
        logic [31:0] rd;
        logic e_req;
        logic [31:0] e_addr, e_instr, e_pc4;
        logic e_valid;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_req();
        return !reset && !m_hbuf && (m_pend || !EXMEM_iord);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_pend ? m_paddr : m_pc;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_paddr = 32'h0; m_buf = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_pend = 1'b0; m_disc = 1'b0; m_hbuf = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_check();
        chk("mem_req", 32'(mem_req), 32'(m_req()));
        if (m_req()) chk("mem_addr", mem_addr, m_addr());
        chk("IFID_instr", IFID_instr, m_instr);
        chk("IFID_pc4", IFID_pc4, m_pc4);
        chk("IFID_valid", 32'(IFID_valid), 32'(m_valid));
        chk("IFID_rs", 32'(IFID_rs), 32'(m_instr[25:21]));
        chk("IFID_rt", 32'(IFID_rt), 32'(m_instr[20:16]));
    endtask

    task automatic model_edge();
        logic iss, avail, adv;
        logic [31:0] a, word;
        iss = m_req();
        a = m_addr();
        adv = PCWrite && IFIDWrite;
        avail = 1'b0;
        word = 32'h0;
        if (flush) begin
            m_pend = iss && !mem_ready;
            m_disc = m_pend;
            m_paddr = a;
            m_pc = branch_target;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_hbuf = 1'b0;
        end else begin
            if (m_hbuf) begin
                avail = 1'b1;
                word = m_buf;
            end else if (iss && mem_ready) begin
                if (!m_disc) begin
                    avail = 1'b1;
                    word = mem_rdata;
                end
                m_disc = 1'b0;
                m_pend = 1'b0;
            end else if (iss) begin
                m_pend = 1'b1;
                m_paddr = a;
            end
            if (avail && adv) begin
                m_instr = word;
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_hbuf = 1'b0;
            end else begin
                if (avail) begin
                    m_hbuf = 1'b1;
                    m_buf = word;
                end
                if (IFIDWrite) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic apply(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt,
                         input logic iord, input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        PCWrite = pcw; IFIDWrite = ifw; flush = fl; branch_target = bt;
        EXMEM_iord = iord; mem_ready = rdy; mem_rdata = rd;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic v(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt,
                     input logic iord, input logic rdy, input logic [31:0] rd, input logic er,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        tbl.push_back('{pcw, ifw, fl, bt, iord, rdy, rd, er, ea, ei, ep, ev});
    endtask

    initial begin
        // streaming, load-use stall, shared port, flush in WAIT, wrap
        v(T,T,F,32'h0,F,T,32'h1111_0000, T,32'h00,32'h0,        32'h00,F);
        v(T,T,F,32'h0,F,T,32'h2222_0000, T,32'h04,32'h1111_0000,32'h04,T);
        v(F,F,F,32'h0,F,T,32'h8C22_0004, T,32'h08,32'h2222_0000,32'h08,T);
        v(F,F,F,32'h0,F,F,32'h0,         F,32'h00,32'h2222_0000,32'h08,T);
        v(T,T,F,32'h0,F,F,32'h0,         F,32'h00,32'h2222_0000,32'h08,T);
        v(T,T,F,32'h0,T,F,32'h0,         F,32'h00,32'h8C22_0004,32'h0C,T);
        v(T,T,F,32'h0,T,F,32'h0,         F,32'h00,32'h0,        32'h0C,F);
        v(T,T,F,32'h0,T,F,32'h0,         F,32'h00,32'h0,        32'h0C,F);
        v(T,T,F,32'h0,F,F,32'h0,         T,32'h0C,32'h0,        32'h0C,F);
        v(T,T,F,32'h0,T,F,32'h0,         T,32'h0C,32'h0,        32'h0C,F);
        v(T,T,F,32'h0,T,T,32'hAAAA_0001, T,32'h0C,32'h0,        32'h0C,F);
        v(T,T,F,32'h0,F,F,32'h0,         T,32'h10,32'hAAAA_0001,32'h10,T);
        v(T,T,T,32'h40,F,F,32'h0,        T,32'h10,32'h0,        32'h10,F);
        v(T,T,F,32'h0,F,F,32'h0,         T,32'h10,32'h0,        32'h10,F);
        v(T,T,F,32'h0,F,T,32'hDEAD_BEEF, T,32'h10,32'h0,        32'h10,F);
        v(T,T,F,32'h0,F,T,32'h1234_5678, T,32'h40,32'h0,        32'h10,F);
        v(T,T,T,32'hFFFF_FFFC,F,T,32'h5555_5555, T,32'h44,32'h1234_5678,32'h44,T);
        v(T,T,F,32'h0,F,T,32'h0BAD_F00D, T,32'hFFFF_FFFC,32'h0, 32'h44,F);
        v(T,T,F,32'h0,F,T,32'h03E2_F820, T,32'h00,32'h0BAD_F00D,32'h00,T);
        v(T,T,F,32'h0,F,F,32'h0,         T,32'h04,32'h03E2_F820,32'h04,T);

        model_reset();
        #2;
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_valid", 32'(IFID_valid), 32'h0);
        #10 reset = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].bt, tbl[i].iord, tbl[i].rdy, tbl[i].rd);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_instr", i), IFID_instr, tbl[i].e_instr);
            chk($sformatf("vec%0d_pc4", i), IFID_pc4, tbl[i].e_pc4);
            chk($sformatf("vec%0d_valid", i), 32'(IFID_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_rs", i), 32'(IFID_rs), 32'(tbl[i].e_instr[25:21]));
            chk($sformatf("vec%0d_rt", i), 32'(IFID_rt), 32'(tbl[i].e_instr[20:16]));
            tick();
        end

        // reset asserted while a request to 0x4 waits for ready
        apply(T, T, F, 32'h0, F, F, 32'h0);
        chk("wait_req_before_reset", 32'(mem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_mem_req", 32'(mem_req), 32'h0);
        chk("midreset_valid", 32'(IFID_valid), 32'h0);
        chk("midreset_instr", IFID_instr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_req", 32'(mem_req), 32'h1);
        chk("post_reset_addr", mem_addr, 32'h0);
        model_check();
        tick();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            apply($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 11) == 0, bt,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
